// File: rtl/ranger_array.sv
// Round-robin multi-sensor HC-SR04 ranger: per-slot trigger, echo timing, intensity levels.
// Optional DIST_SMOOTH_EN averages each complete width with the channel's previous one.
module ranger_array #(
    parameter int CLK_MHZ  = 40,
    parameter int CHANNELS = 2,
    parameter int SLOT_US  = 60000,
    parameter int TRIG_US  = 20,
    parameter int MAX_US   = 3552,
    parameter int LEVELS   = 8,
    parameter int CNT_W    = 16,
    parameter int LVL_W    = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       echo,
    output logic [CHANNELS-1:0]       trig,
    output logic [CHANNELS*LVL_W-1:0] intensity,
    output logic                      valid,
    output logic [CH_W-1:0]           chan,
    output logic [CHANNELS-1:0]       timeout
);

    localparam int BIN = MAX_US / LEVELS;
    localparam int PW  = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam int WW  = CNT_W + 1;

    typedef enum logic [1:0] {TRIG, ARM, MEAS, DONE} state_t;

    state_t              state;
    logic [PW-1:0]       pre;
    logic                tick;
    logic [CHANNELS-1:0] s1, s2;
    logic                es;
    logic [CNT_W-1:0]    slot;
    logic [CNT_W-1:0]    width;
    logic [CH_W-1:0]     ch;
    logic                seen_low;
    logic                slot_end;
    logic                pend;
    logic                pend_ok;
    logic [CNT_W-1:0]    pend_w;
    logic [CH_W-1:0]     pend_ch;
    logic [WW-1:0]       weff;

    assign tick     = (pre == PW'(CLK_MHZ - 1));
    assign es       = s2[ch];
    assign slot_end = tick && (slot == CNT_W'(SLOT_US - 1));

    // Each threshold crossed drops the level by one; no divider needed.
    function automatic logic [LVL_W-1:0] quant(input logic [WW-1:0] w);
        logic [LVL_W-1:0] l;
        l = LVL_W'(LEVELS - 1);
        for (int k = 1; k < LEVELS; k++) begin
            if (w > WW'(BIN * k))
                l = l - 1'b1;
        end
        if (w == '0)
            l = '0;
        return l;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            pre <= '0;
            s1  <= '0;
            s2  <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            s1  <= echo;
            s2  <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TRIG;
            slot     <= '0;
            width    <= '0;
            ch       <= '0;
            seen_low <= 1'b0;
            pend     <= 1'b0;
            pend_ok  <= 1'b0;
            pend_w   <= '0;
            pend_ch  <= '0;
        end else begin
            pend <= 1'b0;
            if (slot_end) begin
                pend     <= 1'b1;
                pend_ok  <= (state == DONE) || (state == MEAS && !es);
                pend_w   <= width;
                pend_ch  <= ch;
                ch       <= (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
                slot     <= '0;
                state    <= TRIG;
                seen_low <= 1'b0;
            end else if (tick) begin
                slot <= slot + 1'b1;
                unique case (state)
                    TRIG: begin
                        if (slot == CNT_W'(TRIG_US - 1)) begin
                            state    <= ARM;
                            seen_low <= 1'b0;
                        end
                    end
                    // A pulse already high on arming is stale until seen low.
                    ARM: begin
                        if (!es)
                            seen_low <= 1'b1;
                        else if (seen_low) begin
                            state <= MEAS;
                            width <= '0;
                        end
                    end
                    MEAS: begin
                        if (!es)
                            state <= DONE;
                        else if (width != '1)
                            width <= width + 1'b1;
                    end
                    DONE: ;
                endcase
            end
        end
    end

`ifdef DIST_SMOOTH_EN
    logic [CNT_W-1:0]    hist [CHANNELS];
    logic [CHANNELS-1:0] hvld;
    logic [CNT_W-1:0]    hprev;
    logic                hv;

    always_comb begin
        hprev = '0;
        hv    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pend_ch == CH_W'(i)) begin
                hprev = hist[i];
                hv    = hvld[i];
            end
        end
        weff = hv ? ({1'b0, hprev} + {1'b0, pend_w} + WW'(1)) >> 1
                  : {1'b0, pend_w};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hvld <= '0;
        end else if (pend) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (pend_ch == CH_W'(i)) begin
                    if (pend_ok) begin
                        hist[i] <= pend_w;
                        hvld[i] <= 1'b1;
                    end else begin
                        hvld[i] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    assign weff = {1'b0, pend_w};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            trig      <= '0;
            intensity <= '0;
            valid     <= 1'b0;
            chan      <= '0;
            timeout   <= '0;
        end else begin
            valid <= pend;
            trig  <= (state == TRIG) ? (CHANNELS'(1) << ch) : '0;
            if (pend) begin
                chan <= pend_ch;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (pend_ch == CH_W'(i)) begin
                        intensity[i*LVL_W +: LVL_W] <= pend_ok ? quant(weff) : '0;
                        timeout[i] <= !pend_ok;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ranger_array.sv
// Directed bench for ranger_array with a per-slot outcome model and cycle-by-cycle compare.
module tb_ranger_array;

    localparam int CLK_MHZ = 2;
    localparam int CH      = 2;
    localparam int SLOT    = 3500;
    localparam int TRIGU   = 20;
    localparam int MAXU    = 3552;
    localparam int LEV     = 8;
    localparam int LW      = 4;
    localparam int BIN     = MAXU / LEV;

    localparam int PULSE = 0, NONE = 1, STUCK = 2, STALE = 3, NOISE = 4;

    logic              clk = 0;
    logic              reset = 1;
    logic [CH-1:0]     echo = '0;
    logic [CH-1:0]     trig;
    logic [CH*LW-1:0]  intensity;
    logic              valid;
    logic [0:0]        chan;
    logic [CH-1:0]     timeout;

    ranger_array #(
        .CLK_MHZ(CLK_MHZ), .CHANNELS(CH), .SLOT_US(SLOT), .TRIG_US(TRIGU),
        .MAX_US(MAXU), .LEVELS(LEV), .CNT_W(16), .LVL_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .echo(echo), .trig(trig),
        .intensity(intensity), .valid(valid), .chan(chan), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {bit ok; int w;} exp_t;
    exp_t q[$];

    int vecs = 0;
    int errs = 0;
    int nvalid = 0;
    int mint[CH];
    int mto[CH];
    int hw[CH];
    bit hv[CH];
    int expch = 0;
    int cyc = 0;
    int last_v = -1;
    int tcnt = 0;
    logic rst_d = 1'b1;
    logic [CH*LW-1:0] ev;
    logic [CH-1:0] et;

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int level_of(input int w);
        if (w == 0 || w > BIN * (LEV - 1))
            return 0;
        return LEV - 1 - (w - 1) / BIN;
    endfunction

    always @(posedge clk) rst_d <= reset;

    // Model: one expected outcome per slot, applied when the result strobe appears.
    always @(negedge clk) begin
        exp_t e;
        int eff;
        cyc++;
        if (rst_d) begin
            check("rst_valid", valid, 0);
            check("rst_trig", trig, 0);
            check("rst_intensity", intensity, 0);
            check("rst_timeout", timeout, 0);
            check("rst_chan", chan, 0);
            for (int i = 0; i < CH; i++) begin
                mint[i] = 0;
                mto[i]  = 0;
                hv[i]   = 0;
            end
            q.delete();
            expch  = 0;
            last_v = -1;
            tcnt   = 0;
        end else begin
            if (valid) begin
                check("valid_chan", chan, expch);
                if (last_v >= 0)
                    check("valid_period", cyc - last_v, SLOT * CLK_MHZ);
                last_v = cyc;
                if (q.size() == 0) begin
                    check("valid_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    if (e.ok) begin
                        eff = e.w;
`ifdef DIST_SMOOTH_EN
                        if (hv[expch])
                            eff = (hw[expch] + e.w + 1) / 2;
                        hw[expch] = e.w;
                        hv[expch] = 1;
`endif
                        mint[expch] = level_of(eff);
                        mto[expch]  = 0;
                    end else begin
                        mint[expch] = 0;
                        mto[expch]  = 1;
                        hv[expch]   = 0;
                    end
                end
                expch = (expch + 1) % CH;
                nvalid++;
            end
            for (int i = 0; i < CH; i++) begin
                ev[i*LW +: LW] = LW'(mint[i]);
                et[i] = mto[i][0];
            end
            check("intensity", intensity, ev);
            check("timeout", timeout, et);
            if (trig != 0) begin
                check("trig_onehot", trig, 1 << expch);
                tcnt++;
            end else if (tcnt != 0) begin
                check("trig_len", tcnt, TRIGU * CLK_MHZ);
                tcnt = 0;
            end
        end
    end

    task automatic us(input int n);
        repeat (n * CLK_MHZ) @(posedge clk);
        #1;
    endtask

    task automatic wait_trig(output int c, output bit ok);
        int k = 0;
        while (trig == 0 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        ok = (trig != 0);
        if (!ok)
            check("trig_wait", 0, 1);
        c = trig[1] ? 1 : 0;
    endtask

    task automatic wait_trig_low();
        int k = 0;
        while (trig != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (trig != 0)
            check("trig_fall_wait", 0, 1);
    endtask

    task automatic run_slot(input int kind, input int w);
        int c, n0, k;
        bit ok;
        exp_t e;
        n0 = nvalid;
        wait_trig(c, ok);
        if (!ok)
            return;
        e.ok = (kind == PULSE || kind == STALE || kind == NOISE);
        e.w  = w;
        q.push_back(e);
        if (kind == STALE)
            echo[c] = 1'b1;
        wait_trig_low();
        case (kind)
            PULSE: begin
                us(100); echo[c] = 1'b1; us(w); echo[c] = 1'b0;
            end
            NOISE: begin
                us(100); echo[1-c] = 1'b1; us(50);
                echo[c] = 1'b1; us(w); echo[c] = 1'b0;
                us(50); echo[1-c] = 1'b0;
            end
            STALE: begin
                us(200); echo[c] = 1'b0; us(100);
                echo[c] = 1'b1; us(w); echo[c] = 1'b0;
            end
            STUCK: begin
                us(100); echo[c] = 1'b1;
            end
            default: ;
        endcase
        k = 0;
        while (nvalid == n0 && k < 8000) begin
            @(negedge clk);
            k++;
        end
        if (nvalid == n0)
            check("valid_wait", 0, 1);
        if (kind == STUCK)
            echo[c] = 1'b0;
    endtask

    initial begin
        int c;
        bit ok;
        repeat (4) @(posedge clk);
        #1 reset = 0;

        run_slot(NOISE, 300);
        check("t1_field0", intensity[3:0], 7);
        check("t1_timeout0", timeout[0], 0);
        check("t1_chan", chan, 0);

        run_slot(PULSE, 1000);
        check("t2_field1", intensity[7:4], 5);
        check("t2_field0_hold", intensity[3:0], 7);
        check("t2_chan", chan, 1);

        run_slot(NONE, 0);
        check("t3_field0", intensity[3:0], 0);
        check("t3_timeout0", timeout[0], 1);

        run_slot(PULSE, 3200);
`ifndef DIST_SMOOTH_EN
        check("t4_field1", intensity[7:4], 0);
`endif
        check("t4_timeout1", timeout[1], 0);
        check("t4_timeout0_hold", timeout[0], 1);

        run_slot(PULSE, 400);
        check("t5_field0", intensity[3:0], 7);
        check("t5_timeout0", timeout[0], 0);

        run_slot(STUCK, 0);
        check("t6_field1", intensity[7:4], 0);
        check("t6_timeout1", timeout[1], 1);

        run_slot(PULSE, 1000);
`ifdef DIST_SMOOTH_EN
        check("t7_field0_avg", intensity[3:0], 6);
`else
        check("t7_field0", intensity[3:0], 5);
`endif

        run_slot(STALE, 500);
        check("t8_field1", intensity[7:4], 6);
        check("t8_timeout1", timeout[1], 0);

        run_slot(NONE, 0);
        check("t9_timeout0", timeout[0], 1);

        wait_trig(c, ok);
        check("t10_slot_ch", c, 1);
        wait_trig_low();
        us(100);
        echo[c] = 1'b1;
        us(300);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t10_trig", trig, 0);
        check("t10_valid", valid, 0);
        check("t10_intensity", intensity, 0);
        check("t10_timeout", timeout, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        echo = '0;

        run_slot(PULSE, 300);
        check("t11_field0", intensity[3:0], 7);
        check("t11_chan", chan, 0);
        check("t11_field1", intensity[7:4], 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
